// File: rtl/preset_shift_reg_pkg.sv
// Shared types for preset_shift_reg: command opcode encoding and burst FSM states.
package preset_shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROTL = 3'b100,
        OP_ROTR = 3'b101,
        OP_CLR  = 3'b110,
        OP_INV  = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/psr_step_unit.sv
// One shift/rotate step of the register; non-step opcodes pass q through unchanged.
module psr_step_unit
    import preset_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_e              op,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next
);

    // Next-value selection for a single step
    always_comb begin
        q_next = q;
        case (op)
            OP_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            OP_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            OP_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROTR: q_next = {q[0], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/preset_shift_reg.sv
// WIDTH-bit register with async reset, sync preset and a load/shift/rotate command port.
// Optional registered even-parity output enabled by PRESET_SHIFT_REG_PARITY_EN.
module preset_shift_reg
    import preset_shift_reg_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
    parameter int               CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
`ifdef PRESET_SHIFT_REG_PARITY_EN
   ,output logic             parity
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_e           state_r, state_nxt;
    op_e              op_r, op_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             done_r, done_nxt;
    op_e              cmd_op_e;
    op_e              step_op;
    logic [WIDTH-1:0] step_q;

    assign cmd_op_e = op_e'(cmd_op);
    // A burst in flight uses its latched op; otherwise the incoming command drives the step.
    assign step_op  = (state_r == ST_SHIFT) ? op_r : cmd_op_e;

    psr_step_unit #(.WIDTH(WIDTH)) u_step (
        .q      (q_r),
        .op     (step_op),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (step_q)
    );

    // Next-state and next-value logic: preset, then burst step, then command accept
    always_comb begin
        q_nxt     = q_r;
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        op_nxt    = op_r;
        done_nxt  = 1'b0;
        if (pr) begin
            q_nxt     = PRESET_VAL;
            state_nxt = ST_IDLE;
            cnt_nxt   = CNT_ZERO;
        end else if (state_r == ST_SHIFT) begin
            q_nxt   = step_q;
            cnt_nxt = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = ST_SHIFT;
            end
        end else if (cmd_valid) begin
            done_nxt = 1'b1;
            case (cmd_op_e)
                OP_LOAD: q_nxt = d;
                OP_CLR:  q_nxt = {WIDTH{1'b0}};
                OP_INV:  q_nxt = ~q_r;
                OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: begin
                    if (cmd_cnt != CNT_ZERO) begin
                        q_nxt   = step_q;
                        cnt_nxt = cmd_cnt - CNT_ONE;
                        op_nxt  = cmd_op_e;
                        if (cmd_cnt == CNT_ONE) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_SHIFT;
                            done_nxt  = 1'b0;
                        end
                    end else begin
                        q_nxt = q_r;
                    end
                end
                default: q_nxt = q_r;
            endcase
        end else begin
            done_nxt = 1'b0;
        end
    end

    // State and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= {WIDTH{1'b0}};
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            op_r    <= OP_HOLD;
            done_r  <= 1'b0;
        end else begin
            q_r     <= q_nxt;
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            op_r    <= op_nxt;
            done_r  <= done_nxt;
        end
    end

`ifdef PRESET_SHIFT_REG_PARITY_EN
    logic parity_r;

    // Parity computed from the next value so it always tracks the current q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= ^q_nxt;
        end
    end

    assign parity = parity_r;
`endif

    assign cmd_ready = (state_r == ST_IDLE) && !pr;
    assign q         = q_r;
    assign qb        = ~q_r;
    assign sout_l    = q_r[WIDTH-1];
    assign sout_r    = q_r[0];
    assign busy      = (state_r == ST_SHIFT);
    assign done      = done_r;

endmodule

// File: tb/tb_preset_shift_reg.sv
// Self-checking bench for preset_shift_reg: directed scenarios plus randomized traffic
// against an arithmetic reference model checked every negative clock edge.
module tb_preset_shift_reg;

    localparam int         W  = 8;
    localparam int         CW = 4;
    localparam logic [7:0] PV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst, pr, cmd_valid, sin_l, sin_r;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_cnt;
    logic [W-1:0]  d;
    logic          cmd_ready, sout_l, sout_r, busy, done;
    logic [W-1:0]  q, qb;
`ifdef PRESET_SHIFT_REG_PARITY_EN
    logic          parity;
`endif

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;

    always #5 clk = ~clk;

    preset_shift_reg #(.WIDTH(W), .PRESET_VAL(PV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pr(pr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .q(q), .qb(qb), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
`ifdef PRESET_SHIFT_REG_PARITY_EN
       ,.parity(parity)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: one step computed with integer arithmetic
    function automatic logic [7:0] model_step(input logic [7:0] v, input logic [2:0] op,
                                              input logic sl, input logic sr);
        int x;
        int r;
        x = int'(v);
        case (op)
            3'b010:  r = (x * 2 + int'(sl)) % 256;
            3'b011:  r = x / 2 + int'(sr) * 128;
            3'b100:  r = (x * 2) % 256 + x / 128;
            3'b101:  r = x / 2 + (x % 2) * 128;
            default: r = x;
        endcase
        return 8'(r);
    endfunction

    logic [7:0] m_q;
    int         m_rem;
    logic [2:0] m_op;
    logic       m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= 8'h00; m_rem <= 0; m_done <= 1'b0; m_op <= 3'b000;
        end else if (pr) begin
            m_q <= PV; m_rem <= 0; m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_q    <= model_step(m_q, m_op, sin_l, sin_r);
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
        end else if (cmd_valid) begin
            m_done <= 1'b1;
            case (cmd_op)
                3'b001: m_q <= d;
                3'b110: m_q <= 8'h00;
                3'b111: m_q <= ~m_q;
                3'b010, 3'b011, 3'b100, 3'b101: begin
                    if (cmd_cnt != 4'd0) begin
                        m_q    <= model_step(m_q, cmd_op, sin_l, sin_r);
                        m_rem  <= int'(cmd_cnt) - 1;
                        m_op   <= cmd_op;
                        m_done <= (cmd_cnt == 4'd1);
                    end
                end
                default: ;
            endcase
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [7:0] e_qb;
        if (chk_en) begin
            e_qb = ~m_q;
            chk("q", q, m_q);
            chk("qb", qb, e_qb);
            chk("sout_l", sout_l, m_q[7]);
            chk("sout_r", sout_r, m_q[0]);
            chk("busy", busy, (m_rem > 0));
            chk("done", done, m_done);
            chk("cmd_ready", cmd_ready, (m_rem == 0) && !pr);
`ifdef PRESET_SHIFT_REG_PARITY_EN
            chk("parity", parity, ^m_q);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; d = data;
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pr = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_cnt = 4'd0;
        d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_qb", qb, 8'hFF);
        chk("rst_ready", cmd_ready, 1'b1);

        pr = 1'b1; cyc(); pr = 1'b0;
        chk("pr_q", q, 8'hA5);
        chk("pr_done", done, 1'b0);

        issue(3'b001, 4'd0, 8'h3C);
        chk("load_q", q, 8'h3C);
        chk("load_done", done, 1'b1);
        cyc();
        chk("load_done_end", done, 1'b0);
        issue(3'b111, 4'd0, 8'h00);
        chk("inv_q", q, 8'hC3);
        issue(3'b110, 4'd0, 8'h00);
        chk("clr_q", q, 8'h00);

        issue(3'b001, 4'd0, 8'h81);
        sin_l = 1'b1;
        issue(3'b010, 4'd3, 8'h00);
        chk("shl_s1", q, 8'h03);
        chk("shl_busy1", busy, 1'b1);
        chk("shl_ready1", cmd_ready, 1'b0);
        cyc();
        chk("shl_s2", q, 8'h07);
        chk("shl_busy2", busy, 1'b1);
        cyc();
        chk("shl_s3", q, 8'h0F);
        chk("shl_busy3", busy, 1'b0);
        chk("shl_done", done, 1'b1);
        chk("shl_ready3", cmd_ready, 1'b1);
        cyc();
        chk("shl_done_end", done, 1'b0);

        issue(3'b001, 4'd0, 8'h01);
        issue(3'b101, 4'd9, 8'h00);
        for (int i = 0; i < 8; i++) cyc();
        chk("rotr9_q", q, 8'h80);
        chk("rotr9_done", done, 1'b1);
        issue(3'b010, 4'd0, 8'h00);
        chk("n0_q", q, 8'h80);
        chk("n0_done", done, 1'b1);

        issue(3'b100, 4'd10, 8'h00);
        cyc();
        cyc();
        pr = 1'b1; cmd_valid = 1'b1; cmd_op = 3'b001; d = 8'hFF;
        #1;
        chk("pr_ready", cmd_ready, 1'b0);
        cyc();
        pr = 1'b0; cmd_valid = 1'b0;
        chk("abort_q", q, 8'hA5);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        cyc();
        chk("abort_q2", q, 8'hA5);
        chk("abort_done2", done, 1'b0);

        issue(3'b001, 4'd0, 8'h07);
`ifdef PRESET_SHIFT_REG_PARITY_EN
        chk("parity_07", parity, 1'b1);
`endif
        issue(3'b100, 4'd5, 8'h00);
        cyc();
        rst = 1'b1;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_ready", cmd_ready, 1'b1);

        for (int n = 0; n < 600; n++) begin
            pr        = ($urandom_range(0, 24) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_cnt   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
            d         = 8'($urandom_range(0, 255));
            sin_l     = 1'($urandom_range(0, 1));
            sin_r     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                #1;
                chk("rnd_arst_q", q, 8'h00);
                rst = 1'b0;
            end
            cyc();
        end

        cmd_valid = 1'b0; pr = 1'b0;
        cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
